// File: rtl/l2_tshr_multiport.sv
`default_nettype none
// ============================================================================
// Module      : l2_tshr_multiport
// Description : Transaction status holding register for the L2 directory.
//               Tracks in-flight coherence transactions keyed by {tag, set},
//               with multi-port combinational lookup, allocate/update/release,
//               duplicate-address protection, occupancy and age watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_tshr_multiport #(
  parameter int ENTRIES        = 8,
  parameter int LOOKUP_PORTS   = 3,
  parameter int TAG_W          = 20,
  parameter int SET_W          = 6,
  parameter int PAYLOAD_W      = 64,
  parameter int WRITE_FIRST    = 0,
  parameter int AGE_W          = 10,
  parameter int TIMEOUT_CYCLES = 512,
  localparam int IDX_W = ($clog2(ENTRIES) < 1) ? 1 : $clog2(ENTRIES),
  localparam int OCC_W = $clog2(ENTRIES + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [LOOKUP_PORTS*TAG_W-1:0]     lookup_tag,
  input  logic [LOOKUP_PORTS*SET_W-1:0]     lookup_set,
  output logic [LOOKUP_PORTS-1:0]           lookup_hit,
  output logic [LOOKUP_PORTS*IDX_W-1:0]     lookup_index,
  output logic [LOOKUP_PORTS*PAYLOAD_W-1:0] lookup_payload,
  input  logic                              alloc_valid,
  input  logic [TAG_W-1:0]                  alloc_tag,
  input  logic [SET_W-1:0]                  alloc_set,
  input  logic [PAYLOAD_W-1:0]              alloc_payload,
  output logic                              alloc_ready,
  output logic [IDX_W-1:0]                  alloc_index,
  output logic                              alloc_dup,
  input  logic                              update_en,
  input  logic [IDX_W-1:0]                  update_index,
  input  logic [PAYLOAD_W-1:0]              update_payload,
  input  logic                              release_en,
  input  logic [IDX_W-1:0]                  release_index,
  output logic                              full,
  output logic                              empty,
  output logic [OCC_W-1:0]                  occupancy,
  output logic                              timeout_valid,
  output logic [IDX_W-1:0]                  timeout_index
);

  localparam logic [AGE_W-1:0] AGE_MAX     = '1;
  localparam logic [AGE_W-1:0] TIMEOUT_AGE = AGE_W'(TIMEOUT_CYCLES);
  localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(ENTRIES);

  // Registered table state
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q     [ENTRIES];
  logic [TAG_W-1:0]     tag_d     [ENTRIES];
  logic [SET_W-1:0]     set_q     [ENTRIES];
  logic [SET_W-1:0]     set_d     [ENTRIES];
  logic [PAYLOAD_W-1:0] payload_q [ENTRIES];
  logic [PAYLOAD_W-1:0] payload_d [ENTRIES];
  logic [AGE_W-1:0]     age_q     [ENTRIES];
  logic [AGE_W-1:0]     age_d     [ENTRIES];
  logic [OCC_W-1:0]     occ_q, occ_d;

  // Per-entry event strobes and allocation view
  logic [ENTRIES-1:0]   rel_hit, upd_hit, alc_hit;
  logic [ENTRIES-1:0]   avail, free_vec, dup_vec;
  logic                 rel_fire, alloc_fire, dup_w, full_w;
  logic [IDX_W-1:0]     free_idx;

  // Lookup view (registered state, or bypassed state when WRITE_FIRST=1)
  logic [ENTRIES-1:0]   lk_valid;
  logic [TAG_W-1:0]     lk_tag     [ENTRIES];
  logic [SET_W-1:0]     lk_set     [ENTRIES];
  logic [PAYLOAD_W-1:0] lk_payload [ENTRIES];

  // Decode release and update into per-entry strobes; release beats update
  always_comb begin
    rel_hit = '0;
    upd_hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rel_hit[i] = enable & release_en & valid_q[i] & (release_index == IDX_W'(i));
      upd_hit[i] = enable & update_en & valid_q[i] & (update_index == IDX_W'(i)) & ~rel_hit[i];
    end
    rel_fire = |rel_hit;
  end

  // Allocation view: free slot search, duplicate check, full and handshake
  always_comb begin
    avail    = (WRITE_FIRST != 0) ? (valid_q & ~rel_hit) : valid_q;
    free_vec = ~avail;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) free_idx = IDX_W'(i);
    end
    dup_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      dup_vec[i] = avail[i] & (tag_q[i] == alloc_tag) & (set_q[i] == alloc_set);
    end
    dup_w       = alloc_valid & (|dup_vec);
    // Without bypass, full tracks the registered counter; with bypass it
    // must see a slot freed by a same-cycle release.
    full_w      = (WRITE_FIRST != 0) ? ~(|free_vec) : (occ_q == OCC_FULL);
    alloc_ready = enable & ~full_w & ~dup_w;
    alloc_fire  = alloc_valid & alloc_ready;
    alc_hit     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      alc_hit[i] = alloc_fire & (free_idx == IDX_W'(i));
    end
  end

  // Build the table view seen by lookups, including same-cycle writes if bypassing
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      lk_valid[i]   = valid_q[i];
      lk_tag[i]     = tag_q[i];
      lk_set[i]     = set_q[i];
      lk_payload[i] = payload_q[i];
      if (WRITE_FIRST != 0) begin
        lk_valid[i] = (valid_q[i] & ~rel_hit[i]) | alc_hit[i];
        if (alc_hit[i]) begin
          lk_tag[i]     = alloc_tag;
          lk_set[i]     = alloc_set;
          lk_payload[i] = alloc_payload;
        end else if (upd_hit[i]) begin
          lk_payload[i] = update_payload;
        end
      end
    end
  end

  // Per-port priority match: lowest matching index wins
  always_comb begin
    lookup_hit     = '0;
    lookup_index   = '0;
    lookup_payload = '0;
    for (int p = 0; p < LOOKUP_PORTS; p++) begin
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (lk_valid[i] && (lk_tag[i] == lookup_tag[p*TAG_W +: TAG_W]) &&
            (lk_set[i] == lookup_set[p*SET_W +: SET_W])) begin
          lookup_hit[p]                           = 1'b1;
          lookup_index[p*IDX_W +: IDX_W]          = IDX_W'(i);
          lookup_payload[p*PAYLOAD_W +: PAYLOAD_W] = lk_payload[i];
        end
      end
    end
  end

  // Next-state for every entry; alloc into a just-released slot takes priority
  always_comb begin
    valid_d = (valid_q & ~rel_hit) | alc_hit;
    for (int i = 0; i < ENTRIES; i++) begin
      tag_d[i]     = tag_q[i];
      set_d[i]     = set_q[i];
      payload_d[i] = payload_q[i];
      age_d[i]     = age_q[i];
      if (alc_hit[i]) begin
        tag_d[i]     = alloc_tag;
        set_d[i]     = alloc_set;
        payload_d[i] = alloc_payload;
        age_d[i]     = '0;
      end else if (rel_hit[i]) begin
        age_d[i]     = '0;
      end else if (upd_hit[i]) begin
        payload_d[i] = update_payload;
        age_d[i]     = '0;
      end else if (enable && valid_q[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i]     = age_q[i] + 1'b1;
      end
    end
    occ_d = occ_q + OCC_W'(alloc_fire) - OCC_W'(rel_fire);
  end

  // Watchdog: lowest-indexed valid entry whose age has reached the limit
  always_comb begin
    timeout_valid = 1'b0;
    timeout_index = '0;
    if (TIMEOUT_CYCLES != 0) begin
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (valid_q[i] && (age_q[i] >= TIMEOUT_AGE)) begin
          timeout_valid = 1'b1;
          timeout_index = IDX_W'(i);
        end
      end
    end
  end

  // Table and counter registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]     <= '0;
        set_q[i]     <= '0;
        payload_q[i] <= '0;
        age_q[i]     <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]     <= tag_d[i];
        set_q[i]     <= set_d[i];
        payload_q[i] <= payload_d[i];
        age_q[i]     <= age_d[i];
      end
    end
  end

  assign alloc_index = free_idx;
  assign alloc_dup   = dup_w;
  assign full        = full_w;
  assign empty       = (occ_q == '0);
  assign occupancy   = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_tshr_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_tshr_multiport
// Description : Scoreboard bench for l2_tshr_multiport. Two instances share
//               stimulus: dut0 without bypass, dut1 with bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_tshr_multiport;
  localparam int LP = 3, TAG_W = 20, SET_W = 6, PW = 64, IDX_W = 3, OCC_W = 4;
  localparam int S_HITS = 0, S_IDX2 = 1, S_PAY2 = 2, S_OCC = 3, S_FULL = 4, S_EMPTY = 5,
                 S_READY = 6, S_AIDX = 7, S_DUP = 8, S_TOV = 9, S_TOI = 10, S_IDX0 = 11,
                 S_PAY0 = 12;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [LP*TAG_W-1:0] lookup_tag;
  logic [LP*SET_W-1:0] lookup_set;
  logic alloc_valid;
  logic [TAG_W-1:0] alloc_tag;
  logic [SET_W-1:0] alloc_set;
  logic [PW-1:0] alloc_payload;
  logic update_en;
  logic [IDX_W-1:0] update_index;
  logic [PW-1:0] update_payload;
  logic release_en;
  logic [IDX_W-1:0] release_index;

  logic [LP-1:0] hit0, hit1;
  logic [LP*IDX_W-1:0] lidx0, lidx1;
  logic [LP*PW-1:0] lpay0, lpay1;
  logic ready0, ready1, dup0, dup1, full0, full1, empty0, empty1, tov0, tov1;
  logic [IDX_W-1:0] aidx0, aidx1, toi0, toi1;
  logic [OCC_W-1:0] occ0, occ1;

  always #5 clk = ~clk;

  l2_tshr_multiport #(.WRITE_FIRST(0), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .lookup_tag(lookup_tag), .lookup_set(lookup_set),
    .lookup_hit(hit0), .lookup_index(lidx0), .lookup_payload(lpay0),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_set(alloc_set),
    .alloc_payload(alloc_payload), .alloc_ready(ready0), .alloc_index(aidx0),
    .alloc_dup(dup0), .update_en(update_en), .update_index(update_index),
    .update_payload(update_payload), .release_en(release_en),
    .release_index(release_index), .full(full0), .empty(empty0),
    .occupancy(occ0), .timeout_valid(tov0), .timeout_index(toi0));

  l2_tshr_multiport #(.WRITE_FIRST(1), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .lookup_tag(lookup_tag), .lookup_set(lookup_set),
    .lookup_hit(hit1), .lookup_index(lidx1), .lookup_payload(lpay1),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_set(alloc_set),
    .alloc_payload(alloc_payload), .alloc_ready(ready1), .alloc_index(aidx1),
    .alloc_dup(dup1), .update_en(update_en), .update_index(update_index),
    .update_payload(update_payload), .release_en(release_en),
    .release_index(release_index), .full(full1), .empty(empty1),
    .occupancy(occ1), .timeout_valid(tov1), .timeout_index(toi1));

  // Scoreboard queues (parallel): name, dut, field, expected value
  string       nq[$];
  int          dq[$];
  int          sq[$];
  logic [63:0] eq[$];
  int tests = 0;
  int fails = 0;

  task automatic exp1(input string n, input int d, input int s, input logic [63:0] e);
    nq.push_back(n); dq.push_back(d); sq.push_back(s); eq.push_back(e);
  endtask

  task automatic exp2(input string n, input int s, input logic [63:0] e);
    exp1(n, 0, s, e);
    exp1(n, 1, s, e);
  endtask

  function automatic logic [63:0] get_out(input int d, input int s);
    logic [63:0] r;
    r = '0;
    case (s)
      S_HITS:  r = (d != 0) ? 64'(hit1) : 64'(hit0);
      S_IDX2:  r = (d != 0) ? 64'(lidx1[2*IDX_W +: IDX_W]) : 64'(lidx0[2*IDX_W +: IDX_W]);
      S_PAY2:  r = (d != 0) ? lpay1[2*PW +: PW] : lpay0[2*PW +: PW];
      S_OCC:   r = (d != 0) ? 64'(occ1) : 64'(occ0);
      S_FULL:  r = (d != 0) ? 64'(full1) : 64'(full0);
      S_EMPTY: r = (d != 0) ? 64'(empty1) : 64'(empty0);
      S_READY: r = (d != 0) ? 64'(ready1) : 64'(ready0);
      S_AIDX:  r = (d != 0) ? 64'(aidx1) : 64'(aidx0);
      S_DUP:   r = (d != 0) ? 64'(dup1) : 64'(dup0);
      S_TOV:   r = (d != 0) ? 64'(tov1) : 64'(tov0);
      S_TOI:   r = (d != 0) ? 64'(toi1) : 64'(toi0);
      S_IDX0:  r = (d != 0) ? 64'(lidx1[0 +: IDX_W]) : 64'(lidx0[0 +: IDX_W]);
      S_PAY0:  r = (d != 0) ? lpay1[0 +: PW] : lpay0[0 +: PW];
      default: r = '1;
    endcase
    return r;
  endfunction

  // Monitor: drain every pending expectation at the falling edge
  always @(negedge clk) begin
    string       n;
    int          d;
    int          s;
    logic [63:0] e;
    logic [63:0] a;
    while (eq.size() > 0) begin
      n = nq.pop_front(); d = dq.pop_front(); s = sq.pop_front(); e = eq.pop_front();
      a = get_out(d, s);
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", n, d, a, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lookup(input int p, input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s);
    lookup_tag[p*TAG_W +: TAG_W] = t;
    lookup_set[p*SET_W +: SET_W] = s;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; update_en = 1'b0; release_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    idle_inputs();
    repeat (2) cyc();
    reset = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    lookup_tag = '0; lookup_set = '0;
    alloc_valid = 1'b0; alloc_tag = '0; alloc_set = '0; alloc_payload = '0;
    update_en = 1'b0; update_index = '0; update_payload = '0;
    release_en = 1'b0; release_index = '0;
    do_reset();

    // ---------------- Phase 1: alloc, dup, fill, release/alloc race ----------
    exp2("rst_empty", S_EMPTY, 1); exp2("rst_full", S_FULL, 0); exp2("rst_occ", S_OCC, 0);
    exp2("rst_ready", S_READY, 1); exp2("rst_aidx", S_AIDX, 0); exp2("rst_hits", S_HITS, 0);
    exp2("rst_dup", S_DUP, 0); exp2("rst_tov", S_TOV, 0); exp2("rst_toi", S_TOI, 0);
    cyc();

    set_lookup(2, 20'h12345, 6'd5);
    alloc_valid = 1'b1; alloc_tag = 20'h12345; alloc_set = 6'd5; alloc_payload = 64'hAA;
    exp2("alloc_ready", S_READY, 1); exp2("alloc_idx0", S_AIDX, 0);
    exp1("bypass_hit", 0, S_HITS, 0); exp1("bypass_hit", 1, S_HITS, 3'b100);
    exp1("bypass_pay", 1, S_PAY2, 64'hAA);
    cyc();

    exp2("dup_flag", S_DUP, 1); exp2("dup_ready", S_READY, 0); exp2("dup_aidx", S_AIDX, 1);
    exp2("lk_hit", S_HITS, 3'b100); exp2("lk_idx", S_IDX2, 0); exp2("lk_pay", S_PAY2, 64'hAA);
    exp2("occ1", S_OCC, 1);
    cyc();

    alloc_valid = 1'b0;
    exp2("occ_after_dup", S_OCC, 1); exp2("dup_low", S_DUP, 0); exp2("empty0", S_EMPTY, 0);
    cyc();

    update_en = 1'b1; update_index = 3'd0; update_payload = 64'h55;
    exp1("upd_pay_now", 0, S_PAY2, 64'hAA); exp1("upd_pay_now", 1, S_PAY2, 64'h55);
    cyc();
    update_en = 1'b0;

    for (int i = 1; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_tag = 20'h100 + 20'(i); alloc_set = 6'(i);
      alloc_payload = 64'h200 + 64'(i);
      exp2("fill_aidx", S_AIDX, 64'(i));
      if (i == 1) exp2("upd_pay_next", S_PAY2, 64'h55);
      cyc();
    end
    alloc_valid = 1'b0;
    exp2("full_flag", S_FULL, 1); exp2("full_occ", S_OCC, 8); exp2("full_ready", S_READY, 0);
    cyc();

    release_en = 1'b1; release_index = 3'd3;
    alloc_valid = 1'b1; alloc_tag = 20'h777; alloc_set = 6'd3; alloc_payload = 64'h777;
    exp1("race_ready", 0, S_READY, 0); exp1("race_full", 0, S_FULL, 1);
    exp1("race_ready", 1, S_READY, 1); exp1("race_full", 1, S_FULL, 0);
    exp1("race_aidx", 1, S_AIDX, 3);
    cyc();

    release_en = 1'b0;
    exp1("race2_ready", 0, S_READY, 1); exp1("race2_aidx", 0, S_AIDX, 3);
    exp1("race2_occ", 0, S_OCC, 7); exp1("race2_full", 0, S_FULL, 0);
    exp1("race2_dup", 1, S_DUP, 1); exp1("race2_ready", 1, S_READY, 0);
    exp1("race2_occ", 1, S_OCC, 8);
    cyc();

    alloc_valid = 1'b0;
    set_lookup(2, 20'h777, 6'd3);
    exp2("race_lk_hit", S_HITS, 3'b100); exp2("race_lk_idx", S_IDX2, 3);
    exp2("race_lk_pay", S_PAY2, 64'h777); exp2("race_occ", S_OCC, 8);
    cyc();

    set_lookup(2, 20'h102, 6'd2);
    update_en = 1'b1; update_index = 3'd2; update_payload = 64'hDEAD;
    release_en = 1'b1; release_index = 3'd2;
    exp1("updrel_hit", 0, S_HITS, 3'b100); exp1("updrel_pay", 0, S_PAY2, 64'h202);
    exp1("updrel_hit", 1, S_HITS, 0);
    cyc();

    idle_inputs();
    exp2("updrel_gone", S_HITS, 0); exp2("updrel_occ", S_OCC, 7); exp2("updrel_aidx", S_AIDX, 2);
    cyc();

    release_en = 1'b1; release_index = 3'd6;
    cyc();
    release_en = 1'b0;
    set_lookup(2, 20'h106, 6'd6);
    update_en = 1'b1; update_index = 3'd6; update_payload = 64'hBEEF;
    exp2("inv_upd_occ", S_OCC, 6); exp2("inv_upd_hit", S_HITS, 0);
    cyc();

    update_en = 1'b0;
    set_lookup(0, 20'h105, 6'd5);
    exp2("inv_upd_occ2", S_OCC, 6); exp2("inv_upd_hit2", S_HITS, 3'b001);
    exp2("lk_port0_idx", S_IDX0, 5); exp2("lk_port0_pay", S_PAY0, 64'h205);
    cyc();

    // ---------------- Phase 2: watchdog and enable freeze --------------------
    do_reset();
    set_lookup(0, 20'hA0001, 6'd11);
    set_lookup(2, 20'hA0004, 6'd14);
    // c0..c4: allocate indices 0..4
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_tag = 20'hA0000 + 20'(i); alloc_set = 6'(10 + i);
      alloc_payload = 64'(i);
      exp2("wd_aidx", S_AIDX, 64'(i));
      cyc();
    end
    alloc_valid = 1'b0;
    // c5..c7: release 0, 2, 3
    release_en = 1'b1; release_index = 3'd0; cyc();
    release_index = 3'd2; cyc();
    release_index = 3'd3; cyc();
    release_en = 1'b0;
    // c8..c17: entry 1 age 6..15
    for (int n = 8; n < 18; n++) begin
      exp2("wd_quiet", S_TOV, 0);
      cyc();
    end
    // c18: entry 1 age 16
    exp2("wd_fire1", S_TOV, 1); exp2("wd_idx1", S_TOI, 1);
    update_en = 1'b1; update_index = 3'd1; update_payload = 64'h1111;
    cyc();
    update_en = 1'b0;
    exp2("wd_clear19", S_TOV, 0); cyc();
    exp2("wd_clear20", S_TOV, 0); cyc();
    // c21: entry 4 age 16
    exp2("wd_fire4", S_TOV, 1); exp2("wd_idx4", S_TOI, 4);
    enable = 1'b0;
    alloc_valid = 1'b1; alloc_tag = 20'hBBBBB; alloc_set = 6'd1; alloc_payload = 64'h9;
    update_en = 1'b1; update_index = 3'd1; update_payload = 64'hEE;
    release_en = 1'b1; release_index = 3'd4;
    for (int n = 21; n < 41; n++) begin
      exp2("dis_ready", S_READY, 0); exp2("dis_occ", S_OCC, 2);
      exp2("dis_hits", S_HITS, 3'b101); exp2("dis_pay", S_PAY0, 64'h1111);
      cyc();
    end
    // c41: re-enable, release entry 4
    enable = 1'b1;
    alloc_valid = 1'b0; update_en = 1'b0;
    release_en = 1'b1; release_index = 3'd4;
    exp2("en_tov", S_TOV, 1); exp2("en_toi", S_TOI, 4); exp2("en_occ", S_OCC, 2);
    exp2("en_pay", S_PAY0, 64'h1111);
    exp1("en_hits", 0, S_HITS, 3'b101); exp1("en_hits", 1, S_HITS, 3'b001);
    cyc();
    release_en = 1'b0;
    // c42..c54: entry 1 age 3..15 (frozen during disable)
    exp2("frz_occ", S_OCC, 1);
    for (int n = 42; n < 55; n++) begin
      exp2("frz_quiet", S_TOV, 0);
      cyc();
    end
    exp2("frz_fire", S_TOV, 1); exp2("frz_idx", S_TOI, 1);
    cyc();

    // ---------------- Asynchronous reset mid-operation ----------------------
    #1;
    reset = 1'b1;
    exp2("arst_empty", S_EMPTY, 1); exp2("arst_occ", S_OCC, 0); exp2("arst_full", S_FULL, 0);
    exp2("arst_tov", S_TOV, 0); exp2("arst_toi", S_TOI, 0); exp2("arst_hits", S_HITS, 0);
    exp2("arst_aidx", S_AIDX, 0); exp2("arst_dup", S_DUP, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    if (eq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL sb_drain: got %0d pending expected 0", eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_tshr_multiport.md
Name: l2_tshr_multiport

Overview:
Parametrised transaction status holding register for the L2 directory controller. It tracks in-flight coherence transactions keyed by {tag, set} and carries an opaque payload (state, owner, sharers) per entry. Compared with the previous TSHR it adds:
- an explicit allocate/update/release interface;
- duplicate-address protection;
- an occupancy counter;
- a per-entry age watchdog that flags stalled transactions.

Parameters:
ENTRIES, 8, number of TSHR entries (≥2).
LOOKUP_PORTS, 3, independent combinational lookup ports.
TAG_W, 20, tag width.
SET_W, 6, set index width.
PAYLOAD_W, 64, opaque per-entry payload width.
WRITE_FIRST, 0, 1 = lookups, duplicate check and free-index selection see same-cycle writes (bypass); 0 = they see registered state only.
AGE_W, 10, width of the per-entry age counter.
TIMEOUT_CYCLES, 512, age at which an entry is flagged; 0 disables the watchdog (must be < 2^AGE_W).
Derived: IDX_W = max(1, clog2(ENTRIES)); OCC_W = clog2(ENTRIES+1).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  global state-update enable
lookup_tag  in  LOOKUP_PORTS*TAG_W  per-port lookup tag
lookup_set  in  LOOKUP_PORTS*SET_W  per-port lookup set
lookup_hit  out  LOOKUP_PORTS  valid entry matches {tag,set}
lookup_index  out  LOOKUP_PORTS*IDX_W  matching entry index
lookup_payload  out  LOOKUP_PORTS*PAYLOAD_W  matching entry payload
alloc_valid  in  1  allocation request
alloc_tag  in  TAG_W  allocation tag
alloc_set  in  SET_W  allocation set
alloc_payload  in  PAYLOAD_W  initial payload
alloc_ready  out  1  allocation will be accepted this cycle
alloc_index  out  IDX_W  index granted (lowest free)
alloc_dup  out  1  alloc_valid and {tag,set} already valid in table
update_en  in  1  payload update request
update_index  in  IDX_W  entry to update
update_payload  in  PAYLOAD_W  new payload
release_en  in  1  free an entry
release_index  in  IDX_W  entry to free
full  out  1  no free entry
empty  out  1  no valid entry
occupancy  out  OCC_W  count of valid entries
timeout_valid  out  1  some valid entry has age ≥ TIMEOUT_CYCLES
timeout_index  out  IDX_W  lowest-indexed timed-out entry

Behaviour:
- Reset values: all entries invalid (payload, tag, set and age zeroed), occupancy=0, empty=1, full=0, lookup_hit=0, alloc_dup=0, timeout_valid=0, timeout_index=0, alloc_index=0. Reset mid-operation discards all entries immediately.
- Lookups are purely combinational.
  - Hit requires entry valid AND tag match AND set match.
  - With multiple hits, the lowest index wins.
  - On a miss, lookup_index=0 and lookup_payload is don't-care.
- Allocation handshake:
  - alloc_ready = enable & !full & !alloc_dup.
  - A transfer occurs when alloc_valid & alloc_ready.
  - On transfer, the entry at alloc_index becomes valid on the next edge with the supplied tag, set and payload, and its age is cleared to 0.
  - alloc_index is the lowest free index and is stable while no transfer occurs.
- alloc_dup is asserted only when alloc_valid is high. The matched entry is unchanged.
- Update:
  - When enable & update_en and the target entry is valid, the payload is replaced and the age is cleared.
  - An update to an invalid entry is ignored. Tag and set are never modified by an update.
- Release:
  - When enable & release_en and the target entry is valid, the entry becomes invalid on the next edge.
  - A release of an invalid entry is a no-op and does not change occupancy.
- Simultaneous events:
  - Update and release to the same index: release wins.
  - Release of X together with alloc:
    - WRITE_FIRST=0: the freed X is not eligible for alloc until the next cycle; full is computed from registered state.
    - WRITE_FIRST=1: X is eligible, and full/alloc_index/alloc_dup/lookups reflect the same-cycle release, update and alloc. Freed slots are visible to allocation, and bypassed alloc/update data is visible to lookups.
  - Alloc and release in the same cycle leave occupancy unchanged.
- Occupancy is a registered counter: +1 on an accepted alloc, −1 on a valid release. full = (occupancy==ENTRIES); empty = (occupancy==0). Occupancy must always equal the popcount of the valid bits.
- Ageing: while enable=1, each valid entry's age increments by 1 per cycle and saturates at 2^AGE_W−1. Ages freeze while enable=0.
- Watchdog: timeout_valid = OR over valid entries of (age ≥ TIMEOUT_CYCLES); it is forced to 0 when TIMEOUT_CYCLES=0. A flag clears when the entry is updated or released.
- enable=0: no state change of any kind; alloc_ready=0. Lookups remain live.

Test Plan:
- Reset, enable=1, no requests → empty=1, full=0, occupancy=0, alloc_ready=1, alloc_index=0, all lookup_hit=0.
- Allocate {tag=0x12345,set=5} with payload 0xAA → next cycle lookup on port 2 gives hit=1, index=0, payload 0xAA; occupancy=1. Re-allocating the same {tag,set} → alloc_dup=1, alloc_ready=0, occupancy stays 1.
- Fill all 8 entries with distinct addresses → full=1, alloc_ready=0. In the same cycle, release index 3 and assert alloc:
  - WRITE_FIRST=0: no transfer that cycle; the next cycle grants index 3.
  - WRITE_FIRST=1: index 3 is granted in that cycle.
- Update and release of entry 2 in the same cycle → entry 2 invalid, payload not written, occupancy decrements by 1. Update of an invalid entry 6 → no change.
- TIMEOUT_CYCLES=16: allocate entries 1 and 4, then hold → timeout_valid rises when entry 1's age reaches 16 (the 16th edge after its allocation), with timeout_index=1. Update entry 1 → timeout_index=4 if entry 4's age ≥16, else timeout_valid=0.
- enable=0 for 20 cycles with alloc/update/release active → table, occupancy and ages unchanged; lookups still return hits; assert reset mid-sequence → all outputs return to reset values asynchronously.
